// File: rtl/piezo_pkg.sv
// Shared definitions for the piezo sound path.
// Holds the note period table (C_LO..C_HI), the owner encodings driven on
// `src`, the scheduler state encoding and a small hour-clamp helper. The
// package is also imported by the tone generator and the keypad logic.
package piezo_pkg;

  // Tone generator period words, one per piano key (low C .. high C).
  localparam logic [15:0] NOTE_C_LO = 16'd3830;
  localparam logic [15:0] NOTE_D    = 16'd3400;
  localparam logic [15:0] NOTE_E    = 16'd3038;
  localparam logic [15:0] NOTE_F    = 16'd2864;
  localparam logic [15:0] NOTE_G    = 16'd2550;
  localparam logic [15:0] NOTE_A    = 16'd2272;
  localparam logic [15:0] NOTE_B    = 16'd2028;
  localparam logic [15:0] NOTE_C_HI = 16'd1912;

  // Indexed by key bit: entry 0 is btn[0] (low C), entry 7 is btn[7] (high C).
  localparam logic [15:0] NOTE_TABLE [8] = '{
    NOTE_C_LO, NOTE_D, NOTE_E, NOTE_F, NOTE_G, NOTE_A, NOTE_B, NOTE_C_HI
  };

  typedef enum logic [1:0] {
    SRC_IDLE  = 2'd0,
    SRC_KEY   = 2'd1,
    SRC_CHIME = 2'd2,
    SRC_ALARM = 2'd3
  } src_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CH_TONE  = 3'd1,
    ST_CH_GAP   = 3'd2,
    ST_AL_TONE  = 3'd3,
    ST_AL_GAP   = 3'd4,
    ST_AL_PAUSE = 3'd5
  } state_t;

  // An hour of 0 or above 12 is treated as 12 strikes.
  function automatic logic [3:0] clamp_hour(input logic [3:0] hour);
    return ((hour == 4'd0) || (hour > 4'd12)) ? 4'd12 : hour;
  endfunction

  function automatic logic is_alarm_state(input state_t st);
    return (st == ST_AL_TONE) || (st == ST_AL_GAP) || (st == ST_AL_PAUSE);
  endfunction

endpackage

// File: rtl/piezo_key_encoder.sv
// Combinational keypad encoder.
// Ports:
//   btn     - piano keys, bit7 = high C ... bit0 = low C
//   period  - tone period of the highest pressed key, 0 when none pressed
//   key_any - 1 when at least one key is pressed
module piezo_key_encoder
  import piezo_pkg::*;
(
  input  logic [7:0]  btn,
  output logic [15:0] period,
  output logic        key_any
);

  // Ascending scan: a higher set bit overwrites a lower one, so the highest
  // pressed key wins.
  always_comb begin
    period = 16'd0;
    for (int i = 0; i < 8; i++) begin
      if (btn[i]) begin
        period = NOTE_TABLE[i];
      end
    end
  end

  assign key_any = |btn;

endmodule

// File: rtl/piezo_sound_sched.sv
// Piezo tone scheduler: shares the single tone generator among the live
// keypad, the hourly chime and the alarm (priority alarm > chime > keypad).
// Ports:
//   clk         - 1 MHz system clock (one cycle = 1 us)
//   rst         - synchronous reset, active-high
//   btn         - piano keys, bit7 = high C ... bit0 = low C
//   chime_trig  - one-cycle pulse at the top of each hour
//   chime_count - hour to strike, sampled with chime_trig
//   alarm_trig  - one-cycle pulse, alarm time reached
//   alarm_stop  - one-cycle pulse, user dismiss
//   tone_period - period word to the tone generator, 0 = silent
//   src         - current owner: 0 idle, 1 keypad, 2 chime, 3 alarm
//   busy        - 1 while a chime or alarm sequence is active
module piezo_sound_sched
  import piezo_pkg::*;
#(
  parameter int TONE_LEN  = 100000,
  parameter int GAP_LEN   = 50000,
  parameter int AL_ON     = 80000,
  parameter int AL_OFF    = 60000,
  parameter int AL_PAUSE  = 400000,
  parameter int AL_BURSTS = 30,
  parameter logic [15:0] CHIME_PER = 16'd3830,
  parameter logic [15:0] ALARM_PER = 16'd1912
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  btn,
  input  logic        chime_trig,
  input  logic [3:0]  chime_count,
  input  logic        alarm_trig,
  input  logic        alarm_stop,
  output logic [15:0] tone_period,
  output logic [1:0]  src,
  output logic        busy
);

  localparam logic [19:0] TONE_LAST  = 20'(TONE_LEN - 1);
  localparam logic [19:0] GAP_LAST   = 20'(GAP_LEN - 1);
  localparam logic [19:0] ON_LAST    = 20'(AL_ON - 1);
  localparam logic [19:0] OFF_LAST   = 20'(AL_OFF - 1);
  localparam logic [19:0] PAUSE_LAST = 20'(AL_PAUSE - 1);
  localparam int          BW         = (AL_BURSTS > 1) ? $clog2(AL_BURSTS) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(AL_BURSTS - 1);

  state_t        state_reg, state_next;
  logic [19:0]   timer_reg;
  logic [3:0]    strikes_reg;
  logic [1:0]    beep_reg;
  logic [BW-1:0] burst_reg;
  logic          pend_reg;
  logic [3:0]    pend_cnt_reg;
  logic [15:0]   tone_reg;
  logic [1:0]    src_reg;
  logic          busy_reg;

  logic [15:0] key_period;
  logic        key_any;
  logic [19:0] phase_last;
  logic        phase_end;
  logic        alarm_go;
  logic        pend_any;
  logic [3:0]  pend_eff_cnt;
  logic [3:0]  rem_strikes;
  state_t      alarm_exit;

  piezo_key_encoder u_key_enc (
    .btn     (btn),
    .period  (key_period),
    .key_any (key_any)
  );

  // A simultaneous dismiss cancels an alarm start.
  assign alarm_go     = alarm_trig && !alarm_stop;
  // A chime trigger landing in the same cycle as the alarm ending is honoured.
  assign pend_any     = pend_reg || chime_trig;
  assign pend_eff_cnt = chime_trig ? clamp_hour(chime_count) : pend_cnt_reg;
  assign alarm_exit   = pend_any ? ST_CH_TONE : ST_IDLE;
  // Strikes still owed if the alarm preempts now; the gap-end decrement has
  // not been applied yet on the last gap cycle.
  assign rem_strikes  = ((state_reg == ST_CH_GAP) && phase_end) ?
                        (strikes_reg - 4'd1) : strikes_reg;

  always_comb begin
    case (state_reg)
      ST_CH_TONE:  phase_last = TONE_LAST;
      ST_CH_GAP:   phase_last = GAP_LAST;
      ST_AL_TONE:  phase_last = ON_LAST;
      ST_AL_GAP:   phase_last = OFF_LAST;
      ST_AL_PAUSE: phase_last = PAUSE_LAST;
      default:     phase_last = 20'd0;
    endcase
  end

  assign phase_end = (timer_reg == phase_last);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (alarm_go)        state_next = ST_AL_TONE;
        else if (chime_trig) state_next = ST_CH_TONE;
      end
      ST_CH_TONE: begin
        if (alarm_go)       state_next = ST_AL_TONE;
        else if (phase_end) state_next = ST_CH_GAP;
      end
      ST_CH_GAP: begin
        if (alarm_go)       state_next = ST_AL_TONE;
        else if (phase_end) state_next = (strikes_reg == 4'd1) ? ST_IDLE : ST_CH_TONE;
      end
      ST_AL_TONE: begin
        if (alarm_stop)     state_next = alarm_exit;
        else if (phase_end) state_next = ST_AL_GAP;
      end
      ST_AL_GAP: begin
        if (alarm_stop)     state_next = alarm_exit;
        else if (phase_end) state_next = (beep_reg == 2'd3) ? ST_AL_PAUSE : ST_AL_TONE;
      end
      ST_AL_PAUSE: begin
        if (alarm_stop)     state_next = alarm_exit;
        else if (phase_end) state_next = (burst_reg == BURST_LAST) ? alarm_exit : ST_AL_TONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= 20'd0;
      strikes_reg  <= 4'd0;
      beep_reg     <= 2'd0;
      burst_reg    <= '0;
      pend_reg     <= 1'b0;
      pend_cnt_reg <= 4'd0;
      tone_reg     <= 16'd0;
      src_reg      <= SRC_IDLE;
      busy_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Every phase end changes state, so a state change doubles as "entry".
      timer_reg <= ((state_next != state_reg) || (state_next == ST_IDLE)) ?
                   20'd0 : timer_reg + 20'd1;

      case (state_reg)
        ST_IDLE: begin
          if (alarm_go) begin
            beep_reg  <= 2'd0;
            burst_reg <= '0;
            if (chime_trig) begin
              pend_reg     <= 1'b1;
              pend_cnt_reg <= clamp_hour(chime_count);
            end
          end else if (chime_trig) begin
            strikes_reg <= clamp_hour(chime_count);
          end
        end
        ST_CH_TONE, ST_CH_GAP: begin
          if (alarm_go) begin
            beep_reg     <= 2'd0;
            burst_reg    <= '0;
            pend_reg     <= (rem_strikes != 4'd0);
            pend_cnt_reg <= rem_strikes;
          end else if ((state_reg == ST_CH_GAP) && phase_end) begin
            strikes_reg <= strikes_reg - 4'd1;
          end
        end
        ST_AL_TONE, ST_AL_GAP, ST_AL_PAUSE: begin
          if (!is_alarm_state(state_next)) begin
            if (pend_any) strikes_reg <= pend_eff_cnt;
            pend_reg <= 1'b0;
          end else begin
            if (chime_trig) begin
              pend_reg     <= 1'b1;
              pend_cnt_reg <= clamp_hour(chime_count);
            end
            // beep 3 wraps to 0 on its way into the pause.
            if ((state_reg == ST_AL_GAP) && phase_end) beep_reg <= beep_reg + 2'd1;
            if ((state_reg == ST_AL_PAUSE) && phase_end) begin
              burst_reg <= burst_reg + 1'b1;
              beep_reg  <= 2'd0;
            end
          end
        end
        default: ;
      endcase

      // Outputs follow the state being entered so they line up with it.
      busy_reg <= (state_next != ST_IDLE);
      case (state_next)
        ST_CH_TONE:  begin tone_reg <= CHIME_PER; src_reg <= SRC_CHIME; end
        ST_CH_GAP:   begin tone_reg <= 16'd0;     src_reg <= SRC_CHIME; end
        ST_AL_TONE:  begin tone_reg <= ALARM_PER; src_reg <= SRC_ALARM; end
        ST_AL_GAP,
        ST_AL_PAUSE: begin tone_reg <= 16'd0;     src_reg <= SRC_ALARM; end
        default: begin
          tone_reg <= key_period;
          src_reg  <= key_any ? SRC_KEY : SRC_IDLE;
        end
      endcase
    end
  end

  assign tone_period = tone_reg;
  assign src         = src_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_piezo_sound_sched.sv
module tb_piezo_sound_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  btn;
  logic        chime_trig;
  logic [3:0]  chime_count;
  logic        alarm_trig;
  logic        alarm_stop;
  logic [15:0] tone_period;
  logic [1:0]  src;
  logic        busy;

  int total  = 0;
  int passed = 0;

  piezo_sound_sched #(
    .TONE_LEN  (10),
    .GAP_LEN   (5),
    .AL_ON     (4),
    .AL_OFF    (3),
    .AL_PAUSE  (8),
    .AL_BURSTS (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .chime_trig  (chime_trig),
    .chime_count (chime_count),
    .alarm_trig  (alarm_trig),
    .alarm_stop  (alarm_stop),
    .tone_period (tone_period),
    .src         (src),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] exp_tone,
                     input logic [1:0] exp_src, input logic exp_busy);
    total++;
    assert ({tone_period, src, busy} === {exp_tone, exp_src, exp_busy}) passed++;
    else $error("FAIL %s: tone/src/busy got %0d/%0d/%0d expected %0d/%0d/%0d",
                tag, tone_period, src, busy, exp_tone, exp_src, exp_busy);
  endtask

  task automatic seg(input string tag, input logic [15:0] exp_tone,
                     input logic [1:0] exp_src, input logic exp_busy, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, exp_tone, exp_src, exp_busy);
      tick(1);
    end
  endtask

  task automatic chime_seq(input string tag, input int strikes);
    for (int s = 0; s < strikes; s++) begin
      seg(tag, 16'd3830, 2'd2, 1'b1, 10);
      seg(tag, 16'd0,    2'd2, 1'b1, 5);
    end
  endtask

  task automatic alarm_seq(input string tag, input int bursts);
    for (int b = 0; b < bursts; b++) begin
      for (int k = 0; k < 4; k++) begin
        seg(tag, 16'd1912, 2'd3, 1'b1, 4);
        seg(tag, 16'd0,    2'd3, 1'b1, 3);
      end
      seg(tag, 16'd0, 2'd3, 1'b1, 8);
    end
  endtask

  initial begin
    rst = 1'b1; btn = 8'd0; chime_trig = 1'b0; chime_count = 4'd0;
    alarm_trig = 1'b0; alarm_stop = 1'b0;
    tick(2);
    chk("reset", 16'd0, 2'd0, 1'b0);
    rst = 1'b0;
    tick(1);
    chk("idle", 16'd0, 2'd0, 1'b0);

    // Keypad: highest pressed key selects the note.
    btn = 8'b0000_0101; tick(1); chk("key_e", 16'd3038, 2'd1, 1'b0);
    btn = 8'b1000_0001; tick(1); chk("key_chi", 16'd1912, 2'd1, 1'b0);
    btn = 8'b0000_0001; tick(1); chk("key_clo", 16'd3830, 2'd1, 1'b0);
    btn = 8'b0001_0000; tick(1); chk("key_g", 16'd2550, 2'd1, 1'b0);
    btn = 8'd0;         tick(1); chk("key_off", 16'd0, 2'd0, 1'b0);

    // Chime of 3 with keys held: keys ignored until the sequence ends.
    btn = 8'hFF; chime_count = 4'd3; chime_trig = 1'b1;
    tick(1);
    chime_trig = 1'b0;
    chime_seq("chime3", 3);
    chk("chime3_keys_after", 16'd1912, 2'd1, 1'b0);
    btn = 8'd0; tick(1);
    chk("chime3_idle", 16'd0, 2'd0, 1'b0);

    // Hour 0 clamps to 12 strikes.
    chime_count = 4'd0; chime_trig = 1'b1;
    tick(1);
    chime_trig = 1'b0;
    chime_seq("chime12", 12);
    chk("chime12_idle", 16'd0, 2'd0, 1'b0);

    // Alarm runs its two bursts and stops by itself.
    alarm_trig = 1'b1;
    tick(1);
    alarm_trig = 1'b0;
    alarm_seq("alarm_auto", 2);
    seg("alarm_auto_idle", 16'd0, 2'd0, 1'b0, 2);

    // Alarm preempts a 4-strike chime after its first strike; dismiss resumes 3.
    chime_count = 4'd4; chime_trig = 1'b1;
    tick(1);
    chime_trig = 1'b0;
    chime_seq("preempt_first", 1);
    chk("preempt_strike2", 16'd3830, 2'd2, 1'b1);
    alarm_trig = 1'b1;
    tick(1);
    alarm_trig = 1'b0;
    seg("preempt_alarm", 16'd1912, 2'd3, 1'b1, 2);
    chk("preempt_alarm", 16'd1912, 2'd3, 1'b1);
    alarm_stop = 1'b1;
    tick(1);
    alarm_stop = 1'b0;
    chime_seq("resume", 3);
    chk("resume_idle", 16'd0, 2'd0, 1'b0);

    // Trigger and dismiss in the same cycle: alarm never starts.
    alarm_trig = 1'b1; alarm_stop = 1'b1;
    tick(1);
    alarm_trig = 1'b0; alarm_stop = 1'b0;
    seg("trig_stop", 16'd0, 2'd0, 1'b0, 3);

    // Chime and alarm together from idle: alarm first, chime pending.
    chime_count = 4'd2; chime_trig = 1'b1; alarm_trig = 1'b1;
    tick(1);
    chime_trig = 1'b0; alarm_trig = 1'b0;
    chk("both_alarm", 16'd1912, 2'd3, 1'b1);
    alarm_stop = 1'b1;
    tick(1);
    alarm_stop = 1'b0;
    chime_seq("both_chime", 2);
    chk("both_idle", 16'd0, 2'd0, 1'b0);

    // Reset mid-alarm with a chime pending: silent, pending gone.
    alarm_trig = 1'b1;
    tick(1);
    alarm_trig = 1'b0;
    chk("rst_alarm", 16'd1912, 2'd3, 1'b1);
    chime_count = 4'd5; chime_trig = 1'b1;
    tick(1);
    chime_trig = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("rst_mid", 16'd0, 2'd0, 1'b0);
    rst = 1'b0;
    tick(1);
    chk("rst_after", 16'd0, 2'd0, 1'b0);
    alarm_trig = 1'b1;
    tick(1);
    alarm_trig = 1'b0;
    chk("rst_alarm2", 16'd1912, 2'd3, 1'b1);
    alarm_stop = 1'b1;
    tick(1);
    alarm_stop = 1'b0;
    seg("rst_no_pending", 16'd0, 2'd0, 1'b0, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
